// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b sync-header block lock with gearbox slip requests.
// Optional hi-BER monitor enabled by the BER_MONITOR_EN macro.
module rx_block_lock #(
  parameter int LOCK_CNT    = 64,
  parameter int WINDOW_CNT  = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 32,
  parameter int BER_WINDOW  = 19531
) (
  input  logic       i_rxc,
  input  logic       i_reset_n,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_valid,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic       o_hi_ber
);
  localparam int SW = $clog2((LOCK_CNT > WINDOW_CNT ? LOCK_CNT : WINDOW_CNT) + 1);
  localparam int IW = $clog2(INVALID_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
  logic [IW-1:0] inv_cnt_q, inv_cnt_d, inv_inc;
  logic [WW-1:0] wait_q, wait_d;
  logic hdr_ok;
  assign hdr_ok = i_rx_header[1] ^ i_rx_header[0];
  assign sh_inc = sh_cnt_q + 1'b1;
  assign inv_inc = inv_cnt_q + IW'(!hdr_ok);
  always_comb begin
    state_d = state_q;
    sh_cnt_d = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    wait_d = wait_q;
    case (state_q)
      HUNT: if (i_rx_valid) begin
        if (!hdr_ok) state_d = SLIP;
        else if (sh_inc == SW'(LOCK_CNT)) begin
          state_d = LOCKED;
          sh_cnt_d = '0;
        end else sh_cnt_d = sh_inc;
      end
      SLIP: begin
        state_d = WAIT;
        sh_cnt_d = '0;
        inv_cnt_d = '0;
        wait_d = '0;
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WW'(SLIP_WAIT - 1)) begin
          state_d = HUNT;
          wait_d = '0;
        end
      end
      LOCKED: if (i_rx_valid) begin
        // loss of lock takes priority over a window that completes on the same block
        if (inv_inc == IW'(INVALID_MAX)) state_d = SLIP;
        else if (sh_inc == SW'(WINDOW_CNT)) begin
          sh_cnt_d = '0;
          inv_cnt_d = '0;
        end else begin
          sh_cnt_d = sh_inc;
          inv_cnt_d = inv_inc;
        end
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge i_rxc or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= HUNT;
      sh_cnt_q <= '0;
      inv_cnt_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      sh_cnt_q <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      wait_q <= wait_d;
    end
  assign o_slip = state_q == SLIP;
  assign o_block_lock = state_q == LOCKED;
`ifdef BER_MONITOR_EN
  localparam int TW = $clog2(BER_WINDOW + 1);
  logic [TW-1:0] ber_tmr_q, ber_tmr_d;
  logic [IW-1:0] ber_cnt_q, ber_cnt_d, ber_inc;
  logic hi_ber_q, hi_ber_d, ber_exp;
  always_comb begin
    ber_exp = ber_tmr_q == TW'(BER_WINDOW - 1);
    ber_inc = (i_rx_valid && !hdr_ok && ber_cnt_q != IW'(INVALID_MAX)) ? ber_cnt_q + 1'b1 : ber_cnt_q;
    ber_tmr_d = ber_exp ? '0 : ber_tmr_q + 1'b1;
    ber_cnt_d = ber_exp ? '0 : ber_inc;
    hi_ber_d = (ber_inc == IW'(INVALID_MAX)) | (hi_ber_q & !ber_exp);
  end
  always_ff @(posedge i_rxc or negedge i_reset_n)
    if (!i_reset_n) begin
      ber_tmr_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      ber_tmr_q <= ber_tmr_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q <= hi_ber_d;
    end
  assign o_hi_ber = hi_ber_q;
`else
  logic unused_ber_window;
  assign unused_ber_window = ^BER_WINDOW;
  assign o_hi_ber = 1'b0;
`endif
endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_rx_block_lock;
  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
  logic [1:0] hdr = 2'b00;
  logic o_slip, o_block_lock, o_hi_ber;
  int checks = 0, errors = 0;
  typedef struct {logic [2:0] e_v; logic [2:0] m_v; string tag;} exp_t;
  exp_t sb[$];
`ifdef BER_MONITOR_EN
  localparam logic [2:0] MAIN_MSK = 3'b110;
`else
  localparam logic [2:0] MAIN_MSK = 3'b111;
`endif
  logic [2:0] msk = MAIN_MSK;
  always #5 clk = ~clk;
  rx_block_lock #(.BER_WINDOW(100)) dut (
    .i_rxc(clk), .i_reset_n(rst_n), .i_rx_header(hdr), .i_rx_valid(vld),
    .o_slip(o_slip), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber)
  );
  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] e, input logic [2:0] m);
    checks++;
    if ((act & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: {slip,lock,hi_ber} got %b expected %b (mask %b) at %0t", tag, act, e, m, $time);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, {o_slip, o_block_lock, o_hi_ber}, e.e_v, e.m_v);
    end
  task automatic cyc(input string tag, input logic [1:0] h, input logic v, input logic es, input logic el, input logic eb);
    hdr = h;
    vld = v;
    @(posedge clk);
    sb.push_back('{e_v: {es, el, eb}, m_v: msk, tag: tag});
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc("in_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask
  initial begin
    #1 chk("reset_state", {o_slip, o_block_lock, o_hi_ber}, 3'b000, 3'b111);
    do_reset();
`ifdef BER_MONITOR_EN
    msk = 3'b001;
    for (int k = 1; k <= 205; k++)
      cyc("ber", k <= 16 ? 2'b11 : 2'b01, k <= 16, 1'b0, 1'b0, k >= 16 && k < 200);
    msk = MAIN_MSK;
    do_reset();
`endif
    for (int i = 0; i < 64; i++) cyc("t1_acquire", 2'b01, 1'b1, 1'b0, i == 63, 1'b0);
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 64; i++)
        cyc("t4_tolerate", (i % 4 == 0 && i < 60) ? 2'b11 : 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cyc("t5_loss", i >= 24 ? 2'b00 : 2'b01, 1'b1, i == 39, i != 39, 1'b0);
    repeat (33) cyc("t5_wait", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc("t2_good", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2_slip", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (33) cyc("t2_wait", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) cyc("t2_relock", 2'b01, 1'b1, 1'b0, i == 63, 1'b0);
    for (int i = 0; i < 16; i++) cyc("burst_loss", 2'b11, 1'b1, i == 15, i != 15, 1'b0);
    repeat (33) cyc("burst_wait", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++)
      cyc("t3_gapped", i % 2 ? 2'b11 : 2'b10, i % 2 == 0, 1'b0, i >= 126, 1'b0);
    for (int i = 0; i < 16; i++) cyc("rst_loss", 2'b00, 1'b1, i == 15, i != 15, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_mid_slip", {o_slip, o_block_lock, o_hi_ber}, 3'b000, 3'b111);
    repeat (2) cyc("in_reset", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) cyc("post_rst_lock", 2'b10, 1'b1, 1'b0, i == 63, 1'b0);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
